// File: rtl/demux_latch_8.sv
// Clocked 1-to-WIDTH addressable demultiplexing register.
// Modes: addressable latch, one-hot decoder, auto-incrementing serial deserializer, hold.
module demux_latch_8 #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d,
    input  logic [AW-1:0]    addr,
    input  logic             enb_n,
    input  logic             clr_n,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    ptr,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0]    MODE_LATCH  = 2'b00;
    localparam logic [1:0]    MODE_DEC    = 2'b01;
    localparam logic [1:0]    MODE_SERIAL = 2'b10;
    localparam logic [AW-1:0] PTR_LAST    = AW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t r_state;

    logic [WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_ptr;
    logic [WIDTH-1:0] w_d_vec;
    logic [WIDTH-1:0] w_q_latch;
    logic [WIDTH-1:0] w_q_dec;
    logic [WIDTH-1:0] w_q_ser;

    // One-hot select vectors for the external address and the serial pointer.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
        assign w_sel_addr[gi] = (addr == AW'(gi));
        assign w_sel_ptr[gi]  = (ptr == AW'(gi));
    end

    assign w_d_vec   = {WIDTH{d}};
    assign w_q_latch = (q & ~w_sel_addr) | (w_sel_addr & w_d_vec);
    assign w_q_dec   = w_sel_addr & w_d_vec;
    assign w_q_ser   = (q & ~w_sel_ptr) | (w_sel_ptr & w_d_vec);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q          <= '0;
            ptr        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            r_state    <= S_IDLE;
        end else begin
            frame_done <= 1'b0;
            if (!clr_n) begin
                q       <= '0;
                ptr     <= '0;
                busy    <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                // Leaving serial mode mid-frame aborts it; the new mode still acts this edge.
                if (mode != MODE_SERIAL && r_state == S_SHIFT) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    ptr     <= '0;
                end
                case (mode)
                    MODE_LATCH: begin
                        if (!enb_n) q <= w_q_latch;
                    end
                    MODE_DEC: begin
                        if (!enb_n) q <= w_q_dec;
                    end
                    MODE_SERIAL: begin
                        if (start) begin
                            // Start (or restart) a frame; a write on this edge lands in bit 0.
                            r_state <= S_SHIFT;
                            busy    <= 1'b1;
                            if (!enb_n) begin
                                q[0] <= d;
                                ptr  <= AW'(1);
                            end else begin
                                ptr  <= '0;
                            end
                        end else if (r_state == S_SHIFT && !enb_n) begin
                            q   <= w_q_ser;
                            ptr <= ptr + AW'(1);
                            if (ptr == PTR_LAST) begin
                                r_state    <= S_IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_latch_8.sv
// Self-checking bench for demux_latch_8: directed scenarios plus randomized traffic
// compared against a behavioural model of the steering rules.
module tb_demux_latch_8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       d = 1'b0;
    logic [2:0] addr = '0;
    logic       enb_n = 1'b1;
    logic       clr_n = 1'b1;
    logic [1:0] mode = 2'b11;
    logic       start = 1'b0;
    logic [7:0] q;
    logic [2:0] ptr;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_q;
    int         m_ptr;
    bit         m_active;
    bit         m_done;

    demux_latch_8 #(.WIDTH(8), .AW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .addr       (addr),
        .enb_n      (enb_n),
        .clr_n      (clr_n),
        .mode       (mode),
        .start      (start),
        .q          (q),
        .ptr        (ptr),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        m_q = '0; m_ptr = 0; m_active = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic t_d, input logic [2:0] t_addr, input logic t_enb_n,
                              input logic t_clr_n, input logic [1:0] t_mode, input logic t_start);
        m_done = 0;
        if (!t_clr_n) begin
            model_reset();
        end else begin
            if (t_mode != 2'b10 && m_active) begin
                m_active = 0;
                m_ptr    = 0;
            end
            case (t_mode)
                2'b00: if (!t_enb_n) m_q[t_addr] = t_d;
                2'b01: if (!t_enb_n) begin m_q = '0; m_q[t_addr] = t_d; end
                2'b10: begin
                    if (t_start) begin
                        m_active = 1;
                        m_ptr    = 0;
                        if (!t_enb_n) begin m_q[0] = t_d; m_ptr = 1; end
                    end else if (m_active && !t_enb_n) begin
                        m_q[m_ptr] = t_d;
                        m_ptr = (m_ptr + 1) % 8;
                        if (m_ptr == 0) begin m_active = 0; m_done = 1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 64'(q), 64'(m_q));
        chk({tag, ".ptr"}, 64'(ptr), 64'(m_ptr));
        chk({tag, ".busy"}, 64'(busy), 64'(m_active));
        chk({tag, ".done"}, 64'(frame_done), 64'(m_done));
    endtask

    // Drives one cycle starting from a falling edge and checks on the next falling edge.
    task automatic cyc(input string tag, input logic t_d, input logic [2:0] t_addr, input logic t_enb_n,
                       input logic t_clr_n, input logic [1:0] t_mode, input logic t_start);
        d = t_d; addr = t_addr; enb_n = t_enb_n; clr_n = t_clr_n; mode = t_mode; start = t_start;
        @(posedge clk);
        model_edge(t_d, t_addr, t_enb_n, t_clr_n, t_mode, t_start);
        @(negedge clk);
        check_all(tag);
        $display("cyc %s d=%0b addr=%0d enb_n=%0b clr_n=%0b mode=%0d start=%0b -> q=%02h ptr=%0d busy=%0b done=%0b",
                 tag, t_d, t_addr, t_enb_n, t_clr_n, t_mode, t_start, q, ptr, busy, frame_done);
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".q_async"}, 64'(q), 64'h0);
        chk({tag, ".ptr_async"}, 64'(ptr), 64'h0);
        chk({tag, ".busy_async"}, 64'(busy), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] pattern;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;

        // Fill with ones, then asynchronous reset mid-cycle
        for (int i = 0; i < 8; i++) cyc("fill", 1'b1, 3'(i), 1'b0, 1'b1, 2'b00, 1'b0);
        chk("fill_ff", 64'(q), 64'hFF);
        async_reset("areset");

        // Synchronous clear suppresses a simultaneous write
        for (int i = 0; i < 8; i++) cyc("fill2", 1'b1, 3'(i), 1'b0, 1'b1, 2'b00, 1'b0);
        cyc("clr", 1'b1, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("clr_q", 64'(q), 64'h0);

        // Latch mode
        cyc("latch", 1'b1, 3'd3, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc("latch", 1'b1, 3'd7, 1'b0, 1'b1, 2'b00, 1'b0);
        cyc("latch", 1'b0, 3'd3, 1'b0, 1'b1, 2'b00, 1'b0);
        chk("latch_q", 64'(q), 64'h80);
        cyc("latch_idle", 1'b1, 3'd1, 1'b1, 1'b1, 2'b00, 1'b0);
        chk("latch_hold", 64'(q), 64'h80);

        // Decoder mode
        for (int i = 0; i < 8; i++) cyc("fill3", 1'b1, 3'(i), 1'b0, 1'b1, 2'b00, 1'b0);
        cyc("dec", 1'b1, 3'd5, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("dec_q20", 64'(q), 64'h20);
        cyc("dec", 1'b0, 3'd2, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("dec_q00", 64'(q), 64'h00);

        // Serial frame 8'h4D with two stalls
        pattern = 8'h4D;
        cyc("ser_start", pattern[0], 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
        for (int i = 1; i < 8; i++) begin
            if (i == 3 || i == 6) cyc("ser_stall", 1'b1, 3'd0, 1'b1, 1'b1, 2'b10, 1'b0);
            cyc("ser_bit", pattern[i], 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        end
        chk("ser_q4d", 64'(q), 64'h4D);
        chk("ser_done", 64'(frame_done), 64'h1);
        chk("ser_busy", 64'(busy), 64'h0);

        // Back-to-back frame 8'hA5
        pattern = 8'hA5;
        cyc("b2b_start", pattern[0], 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
        chk("b2b_done_low", 64'(frame_done), 64'h0);
        for (int i = 1; i < 8; i++) cyc("b2b_bit", pattern[i], 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        chk("b2b_qa5", 64'(q), 64'hA5);
        chk("b2b_done", 64'(frame_done), 64'h1);

        // Restart after 3 bits
        cyc("rst_start", 1'b0, 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
        cyc("rst_bit", 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        cyc("rst_bit", 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        cyc("restart", 1'b1, 3'd0, 1'b1, 1'b1, 2'b10, 1'b1);
        chk("restart_ptr", 64'(ptr), 64'h0);
        chk("restart_q", 64'(q), 64'hA6);

        // Abort: 4 serial bits then a latch write on the switching edge
        cyc("ab_start", 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b1);
        cyc("ab_bit", 1'b0, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        cyc("ab_bit", 1'b0, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        cyc("ab_bit", 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0);
        cyc("abort", 1'b1, 3'd6, 1'b0, 1'b1, 2'b00, 1'b0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_q", 64'(q), 64'hE9);

        // Hold mode freezes q through strobes
        for (int i = 0; i < 5; i++)
            cyc("hold", 1'($urandom), 3'($urandom), 1'b0, 1'b1, 2'b11, 1'($urandom));
        chk("hold_q", 64'(q), 64'hE9);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] r_mode;
            int         sel;
            sel = int'($urandom_range(0, 9));
            r_mode = (sel < 2) ? 2'b00 : (sel == 2) ? 2'b01 : (sel == 3) ? 2'b11 : 2'b10;
            if ($urandom_range(0, 299) == 0) async_reset("rnd_reset");
            cyc("rnd", 1'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 63) != 0), r_mode, ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
